// File: rtl/channel_scheduler.sv
// channel_scheduler: turns decoded UART commands into load/start/stop pulses
// for CH_NUM serial-output engines. Each channel keeps a shadow config, which
// commands write, and an active config, which the engine sees and which is
// refreshed only on LOAD.
//
// Handshake: i_cmd_tick is a one-cycle strobe with no back-pressure. A command
// is always consumed on the edge where the strobe is high: it either targets a
// channel (sel < CH_NUM) or raises o_cmd_err for one cycle and changes nothing.
// i_ch_done_tick and every o_ch_* pulse are single-cycle strobes with no ready.
module channel_scheduler #(
  parameter int DATA_BIT = 32,
  parameter int CH_NUM   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_cmd_tick,
  input  logic [DATA_BIT-1:0]        i_cmd_pattern,
  input  logic [DATA_BIT-1:0]        i_cmd_freq,
  input  logic [3:0]                 i_cmd_sel,
  input  logic                       i_cmd_start,
  input  logic                       i_cmd_stop,
  input  logic                       i_cmd_mode,
  input  logic [CH_NUM-1:0]          i_ch_done_tick,
  output logic [CH_NUM*DATA_BIT-1:0] o_ch_pattern,
  output logic [CH_NUM*DATA_BIT-1:0] o_ch_freq,
  output logic [CH_NUM-1:0]          o_ch_mode,
  output logic [CH_NUM-1:0]          o_ch_load,
  output logic [CH_NUM-1:0]          o_ch_start,
  output logic [CH_NUM-1:0]          o_ch_stop,
  output logic [CH_NUM-1:0]          o_ch_busy,
  output logic                       o_cmd_err,
  output logic [2*CH_NUM-1:0]        o_ch_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } ch_state_e;

  ch_state_e           state_q [CH_NUM];
  ch_state_e           state_d [CH_NUM];
  logic [DATA_BIT-1:0] shadow_pat_q  [CH_NUM];
  logic [DATA_BIT-1:0] shadow_freq_q [CH_NUM];
  logic [DATA_BIT-1:0] act_pat_q     [CH_NUM];
  logic [DATA_BIT-1:0] act_freq_q    [CH_NUM];
  logic [CH_NUM-1:0]   shadow_mode_q;
  logic [CH_NUM-1:0]   act_mode_q;
  logic [CH_NUM-1:0]   pending_q, pending_d;
  logic [CH_NUM-1:0]   load_d, start_d, stop_d, busy_d;
  logic [CH_NUM-1:0]   cmd_hit, start_hit, stop_hit;
  logic                sel_ok;

  // Widened compare so CH_NUM = 16 still fits
  assign sel_ok = ({1'b0, i_cmd_sel} < 5'(CH_NUM));

  // Decode which channel (if any) the current command targets
  always_comb begin
    cmd_hit = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      cmd_hit[k] = i_cmd_tick && sel_ok && (i_cmd_sel == 4'(k));
    end
    start_hit = cmd_hit & {CH_NUM{i_cmd_start}};
    stop_hit  = cmd_hit & {CH_NUM{i_cmd_stop}};
  end

  // Per-channel next state, pending flag and pulse requests; stop beats everything
  always_comb begin
    pending_d = pending_q;
    load_d    = '0;
    start_d   = '0;
    stop_d    = '0;
    busy_d    = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      state_d[k] = state_q[k];
      if (stop_hit[k]) begin
        state_d[k]   = ST_IDLE;
        pending_d[k] = 1'b0;
        stop_d[k]    = 1'b1;
      end else begin
        case (state_q[k])
          ST_IDLE: begin
            if (start_hit[k]) state_d[k] = ST_LOAD;
          end
          ST_LOAD: begin
            state_d[k] = ST_START;
            if (start_hit[k]) pending_d[k] = 1'b1;
          end
          ST_START: begin
            state_d[k] = ST_RUN;
            if (start_hit[k]) pending_d[k] = 1'b1;
          end
          ST_RUN: begin
            if (i_ch_done_tick[k]) begin
              // A start arriving with the done tick reloads straight away
              if (pending_q[k] || start_hit[k]) state_d[k] = ST_LOAD;
              else if (act_mode_q[k])           state_d[k] = ST_START;
              else                              state_d[k] = ST_IDLE;
            end else if (start_hit[k]) begin
              pending_d[k] = 1'b1;
            end
          end
          default: state_d[k] = ST_IDLE;
        endcase
      end
      // Entering LOAD consumes any queued start
      if (state_d[k] == ST_LOAD) begin
        load_d[k]    = 1'b1;
        pending_d[k] = 1'b0;
      end
      start_d[k] = (state_d[k] == ST_START);
      busy_d[k]  = (state_d[k] != ST_IDLE);
    end
  end

  // State, config registers and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k]       <= ST_IDLE;
        shadow_pat_q[k]  <= '0;
        shadow_freq_q[k] <= '0;
        act_pat_q[k]     <= '0;
        act_freq_q[k]    <= '0;
      end
      shadow_mode_q <= '0;
      act_mode_q    <= '0;
      pending_q     <= '0;
      o_ch_load     <= '0;
      o_ch_start    <= '0;
      o_ch_stop     <= '0;
      o_ch_busy     <= '0;
      o_cmd_err     <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= state_d[k];
        if (cmd_hit[k]) begin
          shadow_pat_q[k]  <= i_cmd_pattern;
          shadow_freq_q[k] <= i_cmd_freq;
          shadow_mode_q[k] <= i_cmd_mode;
        end
        // Active config is valid while o_ch_load is high; a same-edge
        // command is forwarded since the shadow is only being written now
        if (load_d[k]) begin
          act_pat_q[k]  <= cmd_hit[k] ? i_cmd_pattern : shadow_pat_q[k];
          act_freq_q[k] <= cmd_hit[k] ? i_cmd_freq    : shadow_freq_q[k];
          act_mode_q[k] <= cmd_hit[k] ? i_cmd_mode    : shadow_mode_q[k];
        end
      end
      pending_q  <= pending_d;
      o_ch_load  <= load_d;
      o_ch_start <= start_d;
      o_ch_stop  <= stop_d;
      o_ch_busy  <= busy_d;
      o_cmd_err  <= i_cmd_tick && !sel_ok;
    end
  end

  // Pack active configs and per-channel FSM state onto flat output buses
  always_comb begin
    o_ch_pattern = '0;
    o_ch_freq    = '0;
    o_ch_state   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      o_ch_pattern[k*DATA_BIT +: DATA_BIT] = act_pat_q[k];
      o_ch_freq[k*DATA_BIT +: DATA_BIT]    = act_freq_q[k];
      o_ch_state[2*k +: 2]                 = state_q[k];
    end
  end

  assign o_ch_mode = act_mode_q;

endmodule

// File: tb/tb_channel_scheduler.sv
// Bench for channel_scheduler: directed scenarios plus a randomized run
// against an event-schedule reference model with an expected-output queue.
module tb_channel_scheduler;

  localparam int DATA_BIT = 32;
  localparam int CH_NUM   = 4;
  localparam int W        = 4*CH_NUM + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       i_cmd_tick = 1'b0;
  logic [DATA_BIT-1:0]        i_cmd_pattern = '0;
  logic [DATA_BIT-1:0]        i_cmd_freq = '0;
  logic [3:0]                 i_cmd_sel = '0;
  logic                       i_cmd_start = 1'b0;
  logic                       i_cmd_stop = 1'b0;
  logic                       i_cmd_mode = 1'b0;
  logic [CH_NUM-1:0]          i_ch_done_tick = '0;
  logic [CH_NUM*DATA_BIT-1:0] o_ch_pattern;
  logic [CH_NUM*DATA_BIT-1:0] o_ch_freq;
  logic [CH_NUM-1:0]          o_ch_mode;
  logic [CH_NUM-1:0]          o_ch_load;
  logic [CH_NUM-1:0]          o_ch_start;
  logic [CH_NUM-1:0]          o_ch_stop;
  logic [CH_NUM-1:0]          o_ch_busy;
  logic                       o_cmd_err;
  logic [2*CH_NUM-1:0]        o_ch_state;

  channel_scheduler #(.DATA_BIT(DATA_BIT), .CH_NUM(CH_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_tick(i_cmd_tick), .i_cmd_pattern(i_cmd_pattern), .i_cmd_freq(i_cmd_freq),
    .i_cmd_sel(i_cmd_sel), .i_cmd_start(i_cmd_start), .i_cmd_stop(i_cmd_stop),
    .i_cmd_mode(i_cmd_mode), .i_ch_done_tick(i_ch_done_tick),
    .o_ch_pattern(o_ch_pattern), .o_ch_freq(o_ch_freq), .o_ch_mode(o_ch_mode),
    .o_ch_load(o_ch_load), .o_ch_start(o_ch_start), .o_ch_stop(o_ch_stop),
    .o_ch_busy(o_ch_busy), .o_cmd_err(o_cmd_err), .o_ch_state(o_ch_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard / reference model ----------------
  // Expected {load, start, stop, busy, err} for the next observed cycle
  logic [W-1:0]        exp_q[$];
  logic [DATA_BIT-1:0] m_spat [CH_NUM];
  logic [DATA_BIT-1:0] m_sfreq[CH_NUM];
  logic [DATA_BIT-1:0] m_apat [CH_NUM];
  logic [DATA_BIT-1:0] m_afreq[CH_NUM];
  logic [CH_NUM-1:0]   m_smode, m_amode, m_busy, m_pend;
  int                  m_load_at [CH_NUM];
  int                  m_start_at[CH_NUM];

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_cmd(input logic [3:0] sel, input logic [DATA_BIT-1:0] pat,
                          input logic [DATA_BIT-1:0] freq, input logic start,
                          input logic stop, input logic mode);
    i_cmd_tick    = 1'b1;
    i_cmd_sel     = sel;
    i_cmd_pattern = pat;
    i_cmd_freq    = freq;
    i_cmd_start   = start;
    i_cmd_stop    = stop;
    i_cmd_mode    = mode;
    @(negedge clk);
    i_cmd_tick     = 1'b0;
    i_ch_done_tick = '0;
  endtask

  task automatic pulse_done(input logic [CH_NUM-1:0] m);
    i_ch_done_tick = m;
    @(negedge clk);
    i_ch_done_tick = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err} !== '0 ||
        o_ch_pattern !== '0 || o_ch_freq !== '0 || o_ch_mode !== '0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%h pat=%h freq=%h mode=%b required all zero",
               {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err}, o_ch_pattern, o_ch_freq, o_ch_mode);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err});
    end
  endtask

  task automatic test_one_shot();
    send_cmd(4'd0, 32'hA5A5_0F0F, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0001, 4'b0000, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL one_shot_load ctl=%h required %h", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, 16'h1001);
    end
    @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0001, 4'b0000, 4'b0001} ||
        o_ch_pattern[31:0] !== 32'hA5A5_0F0F || o_ch_freq[31:0] !== 32'h0000_FFFF || o_ch_mode[0] !== 1'b0) begin
      errors++; $display("FAIL one_shot_start ctl=%h pat=%h freq=%h required ctl=0101 pat=a5a50f0f freq=0000ffff",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[31:0], o_ch_freq[31:0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL one_shot_run ctl=%h required 0001", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    pulse_done(4'b0001);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0) begin
      errors++; $display("FAIL one_shot_done ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0 || o_ch_pattern[31:0] !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL one_shot_after ctl=%h pat=%h required ctl=0 pat=a5a50f0f",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[31:0]);
    end
  endtask

  task automatic test_continuous();
    logic [DATA_BIT-1:0] pat;
    pat = $urandom;
    send_cmd(4'd2, pat, $urandom, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_done(4'b0100);
      checks++;
      if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0100, 4'b0000, 4'b0100} ||
          o_ch_pattern[95:64] !== pat) begin
        errors++; $display("FAIL continuous_restart_%0d ctl=%h pat=%h required ctl=0404 pat=%h",
                           i, {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[95:64], pat);
      end
      @(negedge clk);
      checks++;
      if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b0000, 4'b0100}) begin
        errors++; $display("FAIL continuous_run_%0d ctl=%h required 0004", i, {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
      end
    end
    send_cmd(4'd2, ~pat, $urandom, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b0100, 4'b0000} ||
        o_ch_pattern[95:64] !== pat) begin
      errors++; $display("FAIL continuous_stop ctl=%h pat=%h required ctl=0040 pat=%h",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[95:64], pat);
    end
    pulse_done(4'b0100);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0) begin
      errors++; $display("FAIL continuous_done_after_stop ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
  endtask

  task automatic test_queued_start();
    logic [DATA_BIT-1:0] p1, f2;
    p1 = $urandom;
    f2 = $urandom;
    send_cmd(4'd1, p1, $urandom, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send_cmd(4'd1, 32'h1234_5678, f2, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b0000, 4'b0010} ||
        o_ch_pattern[63:32] !== p1) begin
      errors++; $display("FAIL queued_hold ctl=%h pat=%h required ctl=0002 pat=%h",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[63:32], p1);
    end
    pulse_done(4'b0010);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0010, 4'b0000, 4'b0000, 4'b0010}) begin
      errors++; $display("FAIL queued_load ctl=%h required 2002", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0010, 4'b0000, 4'b0010} ||
        o_ch_pattern[63:32] !== 32'h1234_5678 || o_ch_freq[63:32] !== f2) begin
      errors++; $display("FAIL queued_start ctl=%h pat=%h freq=%h required ctl=0202 pat=12345678 freq=%h",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[63:32], o_ch_freq[63:32], f2);
    end
    @(negedge clk);
    pulse_done(4'b0010);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0) begin
      errors++; $display("FAIL queued_finish ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
  endtask

  task automatic test_bad_sel();
    send_cmd(4'd4, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_cmd_err !== 1'b1 || {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0) begin
      errors++; $display("FAIL bad_sel_err err=%b ctl=%h required err=1 ctl=0", o_cmd_err, {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    @(negedge clk);
    checks++;
    if (o_cmd_err !== 1'b0 || {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0 ||
        o_ch_pattern[31:0] !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL bad_sel_after err=%b ctl=%h pat0=%h required err=0 ctl=0 pat0=a5a50f0f",
                         o_cmd_err, {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[31:0]);
    end
  endtask

  task automatic test_stop_priority();
    send_cmd(4'd3, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b1000, 4'b0000}) begin
      errors++; $display("FAIL start_stop_same ctl=%h required 0080", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0 || o_ch_pattern[127:96] !== '0) begin
      errors++; $display("FAIL start_stop_after ctl=%h pat3=%h required 0 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[127:96]);
    end
    send_cmd(4'd0, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    pulse_done(4'b0001);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0001, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL stop_done_restart ctl=%h required 0101", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    @(negedge clk);
    i_ch_done_tick = 4'b0001;
    send_cmd(4'd0, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0000, 4'b0001, 4'b0000}) begin
      errors++; $display("FAIL stop_done_same ctl=%h required 0010", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== '0) begin
      errors++; $display("FAIL stop_done_after ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
  endtask

  task automatic test_async_reset();
    send_cmd(4'd0, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
    send_cmd(4'd1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (o_ch_busy !== 4'b0011) begin
      errors++; $display("FAIL async_pre_busy busy=%b required 0011", o_ch_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err} !== '0 ||
        o_ch_pattern !== '0 || o_ch_freq !== '0 || o_ch_mode !== '0) begin
      errors++; $display("FAIL async_reset_immediate ctl=%h pat=%h mode=%b required all zero",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err}, o_ch_pattern, o_ch_mode);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err} !== '0) begin
      errors++; $display("FAIL async_reset_hold ctl=%h required 0", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd(4'd0, 32'hA5A5_0F0F, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0001, 4'b0000, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL async_after_load ctl=%h required 1001", {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy});
    end
    @(negedge clk);
    checks++;
    if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy} !== {4'b0000, 4'b0001, 4'b0000, 4'b0001} ||
        o_ch_pattern[31:0] !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL async_after_start ctl=%h pat=%h required 0101 a5a50f0f",
                         {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy}, o_ch_pattern[31:0]);
    end
  endtask

  // Randomized traffic against an event-schedule model: each channel records
  // the cycle numbers at which its load and start pulses are due.
  task automatic test_random();
    int                  cyc;
    logic [W-1:0]        exp_v;
    logic [CH_NUM-1:0]   nl, ns, np, dn_v;
    logic                nerr, tick, st_b, sp_b, md;
    logic [3:0]          sel;
    logic [DATA_BIT-1:0] pat, freq;
    int                  r;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < CH_NUM; k++) begin
      m_spat[k] = '0; m_sfreq[k] = '0; m_apat[k] = '0; m_afreq[k] = '0;
      m_load_at[k] = -1; m_start_at[k] = -1;
    end
    m_smode = '0; m_amode = '0; m_busy = '0; m_pend = '0;
    exp_q.delete();
    exp_q.push_back('0);
    cyc = 0;
    for (int it = 0; it < 2500; it++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err} !== exp_v) begin
        errors++; $display("FAIL random_ctl cyc=%0d got=%h required=%h", cyc,
                           {o_ch_load, o_ch_start, o_ch_stop, o_ch_busy, o_cmd_err}, exp_v);
      end
      for (int k = 0; k < CH_NUM; k++) begin
        if (!exp_v[1+3*CH_NUM+k]) begin
          checks++;
          if (o_ch_pattern[k*DATA_BIT +: DATA_BIT] !== m_apat[k] ||
              o_ch_freq[k*DATA_BIT +: DATA_BIT] !== m_afreq[k] || o_ch_mode[k] !== m_amode[k]) begin
            errors++; $display("FAIL random_active cyc=%0d ch=%0d pat=%h freq=%h mode=%b required %h %h %b", cyc, k,
                               o_ch_pattern[k*DATA_BIT +: DATA_BIT], o_ch_freq[k*DATA_BIT +: DATA_BIT], o_ch_mode[k],
                               m_apat[k], m_afreq[k], m_amode[k]);
          end
        end
      end
      // Stimulus for this cycle
      tick = ($urandom_range(0, 3) == 0);
      sel  = 4'($urandom_range(0, 4));
      pat  = $urandom;
      freq = $urandom;
      r    = $urandom_range(0, 99);
      st_b = (r < 75);
      sp_b = (r >= 65 && r < 85);
      md   = 1'($urandom_range(0, 1));
      for (int k = 0; k < CH_NUM; k++) dn_v[k] = ($urandom_range(0, 5) == 0);
      i_cmd_tick = tick; i_cmd_sel = sel; i_cmd_pattern = pat; i_cmd_freq = freq;
      i_cmd_start = st_b; i_cmd_stop = sp_b; i_cmd_mode = md; i_ch_done_tick = dn_v;
      // Model: what the outputs must be next cycle
      nl = '0; ns = '0; np = '0;
      nerr = tick && (int'(sel) >= CH_NUM);
      for (int k = 0; k < CH_NUM; k++) begin
        logic hit, st, sp, running;
        hit     = tick && (int'(sel) == k);
        st      = hit && st_b;
        sp      = hit && sp_b;
        running = m_busy[k] && (cyc > m_start_at[k]);
        if (hit) begin
          m_spat[k] = pat; m_sfreq[k] = freq; m_smode[k] = md;
        end
        if (sp) begin
          m_busy[k] = 1'b0; m_pend[k] = 1'b0; np[k] = 1'b1;
          m_load_at[k] = -1; m_start_at[k] = -1;
        end else if (!m_busy[k]) begin
          if (st) begin
            m_busy[k] = 1'b1; m_load_at[k] = cyc + 1; m_start_at[k] = cyc + 2;
            m_apat[k] = m_spat[k]; m_afreq[k] = m_sfreq[k]; m_amode[k] = m_smode[k];
          end
        end else if (running && dn_v[k]) begin
          if (m_pend[k] || st) begin
            m_pend[k] = 1'b0; m_load_at[k] = cyc + 1; m_start_at[k] = cyc + 2;
            m_apat[k] = m_spat[k]; m_afreq[k] = m_sfreq[k]; m_amode[k] = m_smode[k];
          end else if (m_amode[k]) begin
            m_start_at[k] = cyc + 1;
          end else begin
            m_busy[k] = 1'b0;
          end
        end else if (st) begin
          m_pend[k] = 1'b1;
        end
        nl[k] = (m_load_at[k] == cyc + 1);
        ns[k] = (m_start_at[k] == cyc + 1);
      end
      exp_q.push_back({nl, ns, np, m_busy, nerr});
      cyc++;
      @(negedge clk);
    end
    i_cmd_tick = 1'b0;
    i_ch_done_tick = '0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d required finish before 1ms", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_queued_start();
    test_bad_sel();
    test_stop_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
